// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell walks the operands LSB-first, one bit per clock.
// Define SERIAL_ADDER_SUB_EN to add the 'sub' input (A - B via ~B and a forced carry-in of 1).
module serial_adder_ctrl #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Single shared 1-bit full adder; returns {carry, sum}.
    function automatic logic [1:0] fa_cell(input logic i_x, input logic i_y, input logic i_c);
        fa_cell = {(i_x & i_y) | (i_x & i_c) | (i_y & i_c), i_x ^ i_y ^ i_c};
    endfunction

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-2:0]   r_res;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;

    logic               w_load;
    logic               w_step;
    logic               w_last;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic [1:0]         w_fa;
    logic [WIDTH-1:0]   w_res_nxt;
    logic [WIDTH-1:0]   w_b_load;
    logic               w_c_load;

    // Operand conditioning for the load edge.
`ifdef SERIAL_ADDER_SUB_EN
    assign w_b_load = sub ? ~b : b;
    assign w_c_load = sub ? 1'b1 : cin;
`else
    assign w_b_load = b;
    assign w_c_load = cin;
`endif

    assign w_fa      = fa_cell(r_a[0], r_b[0], r_carry);
    assign w_res_nxt = {w_fa[0], r_res};

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_SHIFT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (r_cnt == CNT_W'(WIDTH - 1)) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (start) begin
                    w_state_nxt = ST_SHIFT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Control strobes and next values of the registered status outputs.
    always_comb begin
        w_load     = 1'b0;
        w_step     = 1'b0;
        w_last     = 1'b0;
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                w_load     = start;
                w_busy_nxt = start;
            end
            ST_SHIFT: begin
                w_step = 1'b1;
                if (r_cnt == CNT_W'(WIDTH - 1)) begin
                    w_last     = 1'b1;
                    w_done_nxt = 1'b1;
                end else begin
                    w_busy_nxt = 1'b1;
                end
            end
            default: begin
                w_load = 1'b0;
            end
        endcase
    end

    // Operand shifters, carry flop, partial result and bit counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= {WIDTH{1'b0}};
            r_b     <= {WIDTH{1'b0}};
            r_res   <= {(WIDTH-1){1'b0}};
            r_carry <= 1'b0;
            r_cnt   <= {CNT_W{1'b0}};
        end else if (w_load) begin
            r_a     <= a;
            r_b     <= w_b_load;
            r_res   <= {(WIDTH-1){1'b0}};
            r_carry <= w_c_load;
            r_cnt   <= {CNT_W{1'b0}};
        end else if (w_step) begin
            r_a     <= {1'b0, r_a[WIDTH-1:1]};
            r_b     <= {1'b0, r_b[WIDTH-1:1]};
            r_res   <= w_res_nxt[WIDTH-1:1];
            r_carry <= w_fa[1];
            r_cnt   <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt   <= r_cnt;
        end
    end

    // Result is published only on the completing edge, so no partial sums leak out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_sum  <= {WIDTH{1'b0}};
            r_cout <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
            if (w_last) begin
                r_sum  <= w_res_nxt;
                r_cout <= w_fa[1];
            end else begin
                r_sum  <= r_sum;
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl (WIDTH=8); sub-mode vectors run when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub;
`endif
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q[$];

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued result.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got {cout,sum}=0x%0h expected no done", {cout, sum});
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                if ({cout, sum} !== e) begin
                    errors++;
                    $display("FAIL result: got {cout,sum}=0x%0h expected 0x%0h", {cout, sum}, e);
                end
            end
        end
    end

    // Pulse start for one edge with the given operands; returns #1 after the accepting edge.
    task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic ic);
        @(posedge clk);
        #1;
        a = ia; b = ib; cin = ic; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Bounded wait for done, counting busy cycles seen before it.
    task automatic wait_done(input string name, input int exp_busy);
        int  nb;
        bit  seen;
        nb = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
            else if (busy === 1'b1) nb++;
        end
        chk({name, "_done_seen"}, 32'(seen), 32'd1);
        chk({name, "_busy_cycles"}, 32'(nb), 32'(exp_busy));
        chk({name, "_busy_at_done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int t0;
        int t1;
        int t2;
        int cyc;
        int got;
        rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_state", {busy, done, cout, sum}, 32'h0);

        // Basic add and wrap-around.
        exp_q.push_back(9'h096);
        issue(8'h5A, 8'h3C, 1'b0);
        wait_done("basic", 8);
        exp_q.push_back(9'h100);
        issue(8'hFF, 8'h01, 1'b0);
        wait_done("wrap1", 8);
        exp_q.push_back(9'h1FF);
        issue(8'hFF, 8'hFF, 1'b1);
        wait_done("wrap2", 8);

        // Start pulse during SHIFT must be ignored.
        exp_q.push_back(9'h046);
        issue(8'h12, 8'h34, 1'b0);
        repeat (3) @(posedge clk);
        #1 a = 8'hAA; b = 8'hBB; cin = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("ignore", 4);
        @(negedge clk);
        chk("ignore_idle_after", {busy, done}, 32'h0);

        // Back-to-back with start held high.
        @(posedge clk);
        #1 a = 8'h01; b = 8'h02; cin = 1'b1; start = 1'b1;
        repeat (3) exp_q.push_back(9'h004);
        cyc = 0; t0 = -1; t1 = -1; t2 = -1; got = 0;
        for (int i = 0; i < 60 && got < 3; i++) begin
            @(negedge clk);
            cyc++;
            if (done === 1'b1) begin
                if (got == 0) t0 = cyc;
                else if (got == 1) t1 = cyc;
                else begin
                    t2 = cyc;
                    start = 1'b0;
                end
                got++;
            end
        end
        start = 1'b0;
        chk("b2b_count", 32'(got), 32'd3);
        chk("b2b_spacing1", 32'(t1 - t0), 32'd9);
        chk("b2b_spacing2", 32'(t2 - t1), 32'd9);

        // Reset in the middle of SHIFT abandons the operation.
        @(negedge clk);
        issue(8'h0F, 8'h0F, 1'b0);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("midreset_outputs", {busy, done, cout, sum}, 32'h0);
        repeat (12) @(negedge clk);
        chk("midreset_no_pending", 32'(exp_q.size()), 32'd0);
        exp_q.push_back(9'h096);
        issue(8'h5A, 8'h3C, 1'b0);
        wait_done("after_reset", 8);

        // Outputs hold while operands wiggle with start low.
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1 a = 8'(i * 37 + 5); b = 8'(i * 91 + 3); cin = i[0];
            @(negedge clk);
            chk("hold", {done, cout, sum}, {23'h0, 1'b0, 1'b0, 8'h96});
        end

`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b1;
        exp_q.push_back(9'h10F);
        issue(8'h10, 8'h01, 1'b0);
        wait_done("sub1", 8);
        exp_q.push_back(9'h0FF);
        issue(8'h01, 8'h02, 1'b1);
        wait_done("sub2", 8);
        sub = 1'b0;
        exp_q.push_back(9'h096);
        issue(8'h5A, 8'h3C, 1'b0);
        wait_done("sub0", 8);
`endif

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
